// File: rtl/ip_rewrite_lookup_arb_if.sv
// Handshake bundle between the lookup arbiter, the rewrite pipes, the
// configuration writer and the shared flow table.
interface ip_rewrite_lookup_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int KEY_W   = 96,
  parameter int DATA_W  = 64
);
  logic [NUM_REQ-1:0]       req_val;
  logic [NUM_REQ*KEY_W-1:0] req_key;
  logic [NUM_REQ-1:0]       req_rdy;
  logic [NUM_REQ-1:0]       resp_val;
  logic                     resp_hit;
  logic [DATA_W-1:0]        resp_data;
  logic [NUM_REQ-1:0]       resp_rdy;
  logic                     wr_val;
  logic                     wr_rdy;
  logic [KEY_W-1:0]         wr_key;
  logic [DATA_W-1:0]        wr_data;
  logic                     tbl_rd_val;
  logic                     tbl_rd_rdy;
  logic [KEY_W-1:0]         tbl_rd_key;
  logic                     tbl_rd_resp_val;
  logic                     tbl_rd_resp_rdy;
  logic                     tbl_rd_resp_hit;
  logic [DATA_W-1:0]        tbl_rd_resp_data;
  logic                     tbl_wr_val;
  logic                     tbl_wr_rdy;
  logic [KEY_W-1:0]         tbl_wr_key;
  logic [DATA_W-1:0]        tbl_wr_data;

  // Arbiter view
  modport master (
    input  req_val, req_key, resp_rdy, wr_val, wr_key, wr_data,
           tbl_rd_rdy, tbl_rd_resp_val, tbl_rd_resp_hit, tbl_rd_resp_data, tbl_wr_rdy,
    output req_rdy, resp_val, resp_hit, resp_data, wr_rdy,
           tbl_rd_val, tbl_rd_key, tbl_rd_resp_rdy, tbl_wr_val, tbl_wr_key, tbl_wr_data
  );

  // Requesters / writer / table view
  modport slave (
    output req_val, req_key, resp_rdy, wr_val, wr_key, wr_data,
           tbl_rd_rdy, tbl_rd_resp_val, tbl_rd_resp_hit, tbl_rd_resp_data, tbl_wr_rdy,
    input  req_rdy, resp_val, resp_hit, resp_data, wr_rdy,
           tbl_rd_val, tbl_rd_key, tbl_rd_resp_rdy, tbl_wr_val, tbl_wr_key, tbl_wr_data
  );
endinterface

// File: rtl/ip_rewrite_lookup_arb.sv
// Shares one flow table between NUM_REQ lookup pipes (round-robin) and a
// config writer (priority with a starvation guard). One transaction in
// flight at a time so a lookup never sees a partially written entry.
//
// state    | meaning
// IDLE     | arbitrate; accept a write or a lookup in the same cycle
// RD_REQ   | presenting latched key to the table
// RD_RESP  | waiting for the table response
// RESP_OUT | presenting hit/data to the granted requester
// WR       | presenting latched write to the table
module ip_rewrite_lookup_arb #(
  parameter int NUM_REQ      = 4,
  parameter int KEY_W        = 96,
  parameter int DATA_W       = 64,
  parameter int WR_BURST_MAX = 4
) (
  input logic clk,
  input logic rst,
  ip_rewrite_lookup_arb_if.master bus
);
  localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int STREAK_W = $clog2(WR_BURST_MAX + 1);
  localparam logic [PTR_W-1:0]    LAST_REQ  = PTR_W'(NUM_REQ - 1);
  localparam logic [STREAK_W-1:0] STREAK_MX = STREAK_W'(WR_BURST_MAX);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_RESP, RESP_OUT, WR} state_t;

  state_t              state;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    grant_reg;
  logic [STREAK_W-1:0] wr_streak;
  logic [KEY_W-1:0]    rd_key_q;
  logic [KEY_W-1:0]    wr_key_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic                hit_q;
  logic [DATA_W-1:0]   data_q;

  logic                any_req;
  logic                wr_pick;
  logic                rd_pick;
  logic [PTR_W-1:0]    winner;
  logic [KEY_W-1:0]    win_key;
  logic                grant_ack;
  int                  scan_idx;

  // IDLE arbitration: write priority unless it has starved a pending lookup
  always_comb begin
    any_req  = |bus.req_val;
    wr_pick  = (state == IDLE) && bus.wr_val && ((wr_streak < STREAK_MX) || !any_req);
    rd_pick  = (state == IDLE) && !wr_pick && any_req;
    winner   = rr_ptr;
    scan_idx = 0;
    // scanning downward so the closest set bit after rr_ptr is assigned last
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (bus.req_val[scan_idx]) winner = PTR_W'(scan_idx);
    end
  end

  // Per-requester decode of grants, responses and the winning key
  always_comb begin
    win_key   = '0;
    grant_ack = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_rdy[i]  = rd_pick && (winner == PTR_W'(i));
      bus.resp_val[i] = (state == RESP_OUT) && (grant_reg == PTR_W'(i));
      if (winner == PTR_W'(i)) win_key = bus.req_key[i*KEY_W +: KEY_W];
      if (grant_reg == PTR_W'(i)) grant_ack = bus.resp_rdy[i];
    end
  end

  assign bus.wr_rdy          = wr_pick;
  assign bus.resp_hit        = hit_q;
  assign bus.resp_data       = data_q;
  assign bus.tbl_rd_val      = (state == RD_REQ);
  assign bus.tbl_rd_key      = rd_key_q;
  assign bus.tbl_rd_resp_rdy = (state == RD_RESP);
  assign bus.tbl_wr_val      = (state == WR);
  assign bus.tbl_wr_key      = wr_key_q;
  assign bus.tbl_wr_data     = wr_data_q;

  // Transaction sequencing and latching of all table-side payloads
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_reg <= '0;
      wr_streak <= '0;
      rd_key_q  <= '0;
      wr_key_q  <= '0;
      wr_data_q <= '0;
      hit_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_pick) begin
            wr_key_q  <= bus.wr_key;
            wr_data_q <= bus.wr_data;
            if (wr_streak < STREAK_MX) wr_streak <= wr_streak + STREAK_W'(1);
            state <= WR;
          end else if (rd_pick) begin
            rd_key_q  <= win_key;
            grant_reg <= winner;
            rr_ptr    <= (winner == LAST_REQ) ? '0 : winner + PTR_W'(1);
            wr_streak <= '0;
            state     <= RD_REQ;
          end
        end
        RD_REQ:   if (bus.tbl_rd_rdy) state <= RD_RESP;
        RD_RESP: begin
          if (bus.tbl_rd_resp_val) begin
            hit_q  <= bus.tbl_rd_resp_hit;
            data_q <= bus.tbl_rd_resp_data;
            state  <= RESP_OUT;
          end
        end
        RESP_OUT: if (grant_ack) state <= IDLE;
        WR:       if (bus.tbl_wr_rdy) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ip_rewrite_lookup_arb.sv
// Directed bench for ip_rewrite_lookup_arb with a small behavioural flow table.
module tb_ip_rewrite_lookup_arb;
  localparam int KEY_W  = 96;
  localparam int DATA_W = 64;

  logic clk;
  logic rst;
  logic model_clr;
  int   n_tests = 0;
  int   n_fail  = 0;

  ip_rewrite_lookup_arb_if bus ();

  ip_rewrite_lookup_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flow table model: 16 entries, overwrite on key match
  logic [KEY_W-1:0]  mkey  [16];
  logic [DATA_W-1:0] mdata [16];
  logic              mval  [16];
  logic [3:0]        wptr;
  int                widx;
  logic              wfound;

  always_comb begin
    widx   = int'(wptr);
    wfound = 1'b0;
    for (int k = 0; k < 16; k++)
      if (mval[k] && mkey[k] == bus.tbl_wr_key) begin
        widx   = k;
        wfound = 1'b1;
      end
  end

  always @(posedge clk) begin
    if (model_clr) begin
      for (int k = 0; k < 16; k++) mval[k] <= 1'b0;
      wptr <= '0;
    end else if (bus.tbl_wr_val && bus.tbl_wr_rdy) begin
      mkey[widx]  <= bus.tbl_wr_key;
      mdata[widx] <= bus.tbl_wr_data;
      mval[widx]  <= 1'b1;
      if (!wfound) wptr <= wptr + 4'd1;
    end
  end

  always_comb begin
    bus.tbl_rd_resp_hit  = 1'b0;
    bus.tbl_rd_resp_data = '0;
    for (int k = 0; k < 16; k++)
      if (mval[k] && mkey[k] == bus.tbl_rd_key) begin
        bus.tbl_rd_resp_hit  = 1'b1;
        bus.tbl_rd_resp_data = mdata[k];
      end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  localparam logic [KEY_W-1:0]  K  = 96'hC0A80001_0A000001_1F40_0050;
  localparam logic [DATA_W-1:0] DB = 64'h0000_0000_DEAD_BEEF;
  localparam logic [KEY_W-1:0]  KW = 96'h0A000001_0A000002_1F90_0050;
  localparam logic [DATA_W-1:0] DW = 64'h1234_5678_9ABC_DEF0;

  initial begin
    logic [3:0] exp_oh;
    rst                 = 1'b1;
    model_clr           = 1'b1;
    bus.req_val         = '0;
    bus.req_key         = '0;
    bus.resp_rdy        = '0;
    bus.wr_val          = 1'b0;
    bus.wr_key          = '0;
    bus.wr_data         = '0;
    bus.tbl_rd_rdy      = 1'b1;
    bus.tbl_rd_resp_val = 1'b1;
    bus.tbl_wr_rdy      = 1'b1;
    nxt();
    nxt();
    model_clr = 1'b0;
    rst       = 1'b0;

    // Reset state
    #1;
    chk("rst_req_rdy",  128'(bus.req_rdy),    128'(4'b0000));
    chk("rst_wr_rdy",   128'(bus.wr_rdy),     128'(1'b0));
    chk("rst_resp_val", 128'(bus.resp_val),   128'(4'b0000));
    chk("rst_rd_val",   128'(bus.tbl_rd_val), 128'(1'b0));
    chk("rst_wr_val",   128'(bus.tbl_wr_val), 128'(1'b0));
    chk("rst_rd_key",   128'(bus.tbl_rd_key), 128'(0));

    // Preload K -> DEADBEEF through the write path
    bus.wr_val = 1'b1; bus.wr_key = K; bus.wr_data = DB;
    #1 chk("pre_wr_rdy", 128'(bus.wr_rdy), 128'(1'b1));
    nxt();
    bus.wr_val = 1'b0;
    #1 chk("pre_tbl_wr_val", 128'(bus.tbl_wr_val), 128'(1'b1));
    nxt();

    // Single lookup from requester 2
    bus.req_val = 4'b0100;
    bus.req_key[2*KEY_W +: KEY_W] = K;
    bus.resp_rdy = 4'b0100;
    #1 chk("sl_req_rdy_T", 128'(bus.req_rdy), 128'(4'b0100));
    nxt();
    bus.req_val = '0;
    #1 chk("sl_rd_val_T1", 128'(bus.tbl_rd_val), 128'(1'b1));
    chk("sl_rd_key_T1", 128'(bus.tbl_rd_key), 128'(K));
    nxt();
    #1 chk("sl_resp_rdy_T2", 128'(bus.tbl_rd_resp_rdy), 128'(1'b1));
    chk("sl_resp_val_T2", 128'(bus.resp_val), 128'(4'b0000));
    nxt();
    #1 chk("sl_resp_val_T3", 128'(bus.resp_val), 128'(4'b0100));
    chk("sl_hit_T3",  128'(bus.resp_hit),  128'(1'b1));
    chk("sl_data_T3", 128'(bus.resp_data), 128'(DB));
    nxt();
    #1 chk("sl_idle_T4", 128'(bus.resp_val), 128'(4'b0000));

    // Round-robin from reset: 0,1,2,3,0
    do_reset();
    bus.req_val  = 4'b1111;
    bus.resp_rdy = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_oh = 4'(1 << (g % 4));
      #1 chk("rr_grant", 128'(bus.req_rdy), 128'(exp_oh));
      nxt(); nxt(); nxt();
      #1 chk("rr_resp_val", 128'(bus.resp_val), 128'(exp_oh));
      nxt();
    end
    bus.req_val = '0;

    // Write priority with starvation guard: W W W W R W
    do_reset();
    bus.req_val = 4'b0010;
    bus.wr_val  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.wr_key  = 96'(32'h100 + i);
      bus.wr_data = 64'(i);
      if (i == 4) begin
        #1 chk("wp_rd_grant", 128'(bus.req_rdy), 128'(4'b0010));
        chk("wp_no_wr_rdy", 128'(bus.wr_rdy), 128'(1'b0));
        nxt();
        #1 chk("wp_rd_val", 128'(bus.tbl_rd_val), 128'(1'b1));
        chk("wp_no_tbl_wr", 128'(bus.tbl_wr_val), 128'(1'b0));
        nxt(); nxt();
        #1 chk("wp_resp_val", 128'(bus.resp_val), 128'(4'b0010));
        nxt();
      end else begin
        #1 chk("wp_wr_grant", 128'(bus.wr_rdy), 128'(1'b1));
        chk("wp_no_rd_grant", 128'(bus.req_rdy), 128'(4'b0000));
        nxt();
        #1 chk("wp_tbl_wr_val", 128'(bus.tbl_wr_val), 128'(1'b1));
        nxt();
      end
    end
    bus.wr_val  = 1'b0;
    bus.req_val = '0;

    // Backpressure on table read and on requester 0's response
    do_reset();
    bus.req_val = 4'b0001;
    bus.req_key[0 +: KEY_W] = K;
    bus.tbl_rd_rdy = 1'b0;
    bus.resp_rdy   = 4'b0010;
    #1 chk("bp_grant", 128'(bus.req_rdy), 128'(4'b0001));
    nxt();
    bus.req_val = 4'b0011;
    bus.wr_val  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1 chk("bp_rd_val",  128'(bus.tbl_rd_val), 128'(1'b1));
      chk("bp_rd_key",  128'(bus.tbl_rd_key), 128'(K));
      chk("bp_no_grant", 128'({bus.req_rdy, bus.wr_rdy, bus.tbl_wr_val}), 128'(0));
      nxt();
    end
    bus.tbl_rd_rdy = 1'b1;
    #1 chk("bp_rd_val_rel", 128'(bus.tbl_rd_val), 128'(1'b1));
    nxt();
    #1 chk("bp_resp_rdy", 128'(bus.tbl_rd_resp_rdy), 128'(1'b1));
    nxt();
    for (int c = 0; c < 3; c++) begin
      #1 chk("bp_resp_val",  128'(bus.resp_val),  128'(4'b0001));
      chk("bp_resp_data", 128'(bus.resp_data), 128'(DB));
      chk("bp_no_wr", 128'({bus.wr_rdy, bus.tbl_wr_val, bus.req_rdy}), 128'(0));
      nxt();
    end
    bus.resp_rdy = 4'b0001;
    #1 chk("bp_resp_hold", 128'(bus.resp_val), 128'(4'b0001));
    nxt();
    #1 chk("bp_wr_after", 128'(bus.wr_rdy), 128'(1'b1));
    chk("bp_resp_clr", 128'(bus.resp_val), 128'(4'b0000));
    bus.req_val = '0;
    nxt();
    bus.wr_val = 1'b0;
    nxt();

    // Read-after-write of KW
    bus.wr_val = 1'b1; bus.wr_key = KW; bus.wr_data = DW;
    bus.req_val = 4'b0100;
    bus.req_key[2*KEY_W +: KEY_W] = KW;
    bus.resp_rdy = 4'b1111;
    #1 chk("raw_wr_first", 128'({bus.wr_rdy, bus.req_rdy}), 128'(5'b10000));
    nxt();
    bus.wr_val = 1'b0;
    #1 chk("raw_tbl_wr_key",  128'(bus.tbl_wr_key),  128'(KW));
    chk("raw_tbl_wr_data", 128'(bus.tbl_wr_data), 128'(DW));
    chk("raw_no_rd_yet", 128'({bus.tbl_wr_val, bus.tbl_rd_val}), 128'(2'b10));
    nxt();
    #1 chk("raw_rd_grant", 128'(bus.req_rdy), 128'(4'b0100));
    nxt();
    bus.req_val = '0;
    #1 chk("raw_rd_val", 128'({bus.tbl_rd_val, bus.tbl_wr_val}), 128'(2'b10));
    nxt(); nxt();
    #1 chk("raw_resp_val",  128'(bus.resp_val),  128'(4'b0100));
    chk("raw_resp_hit",  128'(bus.resp_hit),  128'(1'b1));
    chk("raw_resp_data", 128'(bus.resp_data), 128'(DW));
    nxt();

    // Reset while in RESP_OUT
    bus.req_val  = 4'b0010;
    bus.resp_rdy = '0;
    #1 chk("rr_mid_grant", 128'(bus.req_rdy), 128'(4'b0010));
    nxt();
    bus.req_val = '0;
    nxt(); nxt();
    #1 chk("mid_resp_val", 128'(bus.resp_val), 128'(4'b0010));
    rst = 1'b1;
    nxt();
    #1 chk("mid_rst_resp_val", 128'(bus.resp_val), 128'(4'b0000));
    chk("mid_rst_rd_val", 128'({bus.tbl_rd_val, bus.tbl_rd_resp_rdy}), 128'(0));
    rst = 1'b0;
    bus.req_val = 4'b1111;
    #1 chk("mid_rst_rr_ptr", 128'(bus.req_rdy), 128'(4'b0001));
    bus.req_val = '0;
    nxt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ip_rewrite_lookup_arb.md
# ip_rewrite_lookup_arb

Arbiter that shares one IP-rewrite flow table between NUM_REQ rewrite pipe controllers and a single table-configuration writer. It serialises lookups (round-robin among pipes) and entry writes (priority, with a starvation guard), one transaction in flight, so reads never observe a half-written entry. Sits between the per-pipe lookup handshakes (`lookup_rd_table_val/rdy`) and the flow table / CAM.

## Interface
Parameters:
- NUM_REQ, 4, number of lookup requesters (≥2)
- KEY_W, 96, flow key width (src IP, dst IP, src port, dst port)
- DATA_W, 64, rewrite entry width
- WR_BURST_MAX, 4, max consecutive writes granted while a lookup is pending

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_val  in  NUM_REQ  per-requester lookup valid
- req_key  in  NUM_REQ*KEY_W  lookup keys; requester i at [i*KEY_W +: KEY_W]
- req_rdy  out  NUM_REQ  lookup accepted (one-hot or zero)
- resp_val  out  NUM_REQ  response valid to the granted requester (one-hot or zero)
- resp_hit  out  1  broadcast hit flag
- resp_data  out  DATA_W  broadcast entry data
- resp_rdy  in  NUM_REQ  requester accepts response
- wr_val / wr_rdy  in / out  1  config write handshake
- wr_key  in  KEY_W;  wr_data  in  DATA_W  write payload
- tbl_rd_val / tbl_rd_rdy  out / in  1  table lookup handshake
- tbl_rd_key  out  KEY_W  registered lookup key
- tbl_rd_resp_val / tbl_rd_resp_rdy  in / out  1  table response handshake
- tbl_rd_resp_hit  in  1;  tbl_rd_resp_data  in  DATA_W
- tbl_wr_val / tbl_wr_rdy  out / in  1  table write handshake
- tbl_wr_key  out  KEY_W;  tbl_wr_data  out  DATA_W  registered write payload

## Operation
- States: IDLE, RD_REQ, RD_RESP, RESP_OUT, WR.
- IDLE decision (combinational, same cycle):
  - write chosen if wr_val and (wr_streak < WR_BURST_MAX or no req_val set);
  - else read chosen if any req_val: winner = first set bit scanning rr_ptr, rr_ptr+1, … mod NUM_REQ.
- Write chosen: wr_rdy=1, latch key/data, wr_streak += 1 (saturating at WR_BURST_MAX) -> WR.
- Read chosen: req_rdy[winner]=1, latch key into tbl_rd_key, grant_reg<=winner, rr_ptr<=(winner+1) mod NUM_REQ, wr_streak<=0 -> RD_REQ.
- RD_REQ: tbl_rd_val=1; on tbl_rd_rdy -> RD_RESP.
- RD_RESP: tbl_rd_resp_rdy=1; on tbl_rd_resp_val latch hit/data -> RESP_OUT.
- RESP_OUT: resp_val[grant_reg]=1, resp_hit/resp_data from latch; on resp_rdy[grant_reg] -> IDLE.
- WR: tbl_wr_val=1; on tbl_wr_rdy -> IDLE.
- No write is issued while a read is anywhere between RD_REQ and RESP_OUT, and vice versa.
- wr_streak clears only on a read grant; with no lookups pending, writes are granted back-to-back indefinitely.
- resp_rdy of non-granted requesters and req_key of non-winners are ignored.

## Timing
- Reset: state IDLE, rr_ptr 0, wr_streak 0, grant_reg 0, latched key/data/hit 0. All valid/rdy outputs 0 except those asserted combinationally in IDLE by the arbitration rule.
- Minimum lookup: accept cycle T (IDLE), tbl_rd_val at T+1. With tbl_rd_rdy=1 and response in the same cycle as accept, response captured T+2, resp_val at T+3. Back in IDLE at T+4 if resp_rdy=1.
- Minimum write: accept T, tbl_wr_val T+1, IDLE T+2.
- Throughput: one transaction per ≥4 cycles (reads) or ≥2 cycles (writes).
- All table-side outputs are registered/held stable while their val is high and rdy is low.
- Simultaneous wr_val and req_val with wr_streak < WR_BURST_MAX: write wins.
- rr_ptr wraps from NUM_REQ-1 to 0.
- rst mid-transaction returns to IDLE next cycle and drops in-flight state. The table shares rst and discards its outstanding response.

## Test plan
- Single lookup: req_val[2]=1 with key K, table hits with data 0xDEAD_BEEF → req_rdy[2] at T, tbl_rd_val at T+1, resp_val=4'b0100 with resp_hit=1 and resp_data=0xDEADBEEF at T+3.
- Round-robin: all four req_val held high → grant order 0,1,2,3,0. No requester is granted twice before the others.
- Write priority/starvation: wr_val held high with req_val[1] high (WR_BURST_MAX=4) → exactly 4 writes, then one read to requester 1, then writes resume.
- Backpressure: tbl_rd_rdy low 5 cycles and resp_rdy[0] low 3 cycles → tbl_rd_key and resp_data stay stable, no new grants, and no write is issued meanwhile.
- Read-after-write: write key K data D then lookup K → tbl_wr handshake completes before tbl_rd_val rises, and the response returns D.
- Reset mid-RESP_OUT: assert rst → next cycle all resp_val=0, state IDLE, rr_ptr=0.
